// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues one request at a time to a
// variable-latency instruction memory and buffers {pc, word} pairs for decode.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         pause,
    input  logic                         redirect,
    input  logic [31:0]                  redirect_pc,
    output logic                         imem_req,
    output logic [31:0]                  imem_addr,
    input  logic                         imem_rvalid,
    input  logic [31:0]                  imem_rdata,
    output logic                         inst_valid,
    input  logic                         inst_ready,
    output logic [31:0]                  instruction,
    output logic [31:0]                  inst_pc,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [31:0]   word_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];
    logic          push;
    logic          pop;

    // A redirect cancels both the push of a same-cycle response and any pop.
    assign push        = (state == WAIT) && imem_rvalid && !redirect;
    assign inst_valid  = (count != '0) && !pause;
    assign pop         = inst_valid && inst_ready && !redirect;
    assign instruction = (count != '0) ? word_mem[head] : 32'h0;
    assign inst_pc     = (count != '0) ? pc_mem[head]   : 32'h0;

    always_ff @(posedge clk) begin
        if (push) begin
            word_mem[tail] <= imem_rdata;
            pc_mem[tail]   <= fetch_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            count     <= '0;
            head      <= '0;
            tail      <= '0;
        end else begin
            if (redirect) begin
                count    <= '0;
                head     <= '0;
                tail     <= '0;
                fetch_pc <= redirect_pc & ~32'h3;
            end else begin
                if (push) begin
                    tail     <= tail + PW'(1);
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (pop) head <= head + PW'(1);
                if (push && !pop) count <= count + CW'(1);
                else if (!push && pop) count <= count - CW'(1);
            end

            // Space is checked only at issue; count cannot grow while a request is in flight.
            case (state)
                IDLE: begin
                    if (!pause && (count < FULL) && !redirect) begin
                        imem_req  <= 1'b1;
                        imem_addr <= fetch_pc;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        imem_req <= 1'b0;
                        state    <= IDLE;
                    end else if (redirect) begin
                        state <= DROP;
                    end
                end
                DROP: begin
                    if (imem_rvalid) begin
                        imem_req <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    imem_req <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: transaction-level reference model (queue of {pc, word}
// plus outstanding/discard flags) compared every cycle, with directed scenarios.
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset, pause, redirect, imem_rvalid, inst_ready;
    logic [31:0] redirect_pc, imem_rdata;
    logic        imem_req, inst_valid;
    logic [31:0] imem_addr, instruction, inst_pc;
    logic [2:0]  count;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset), .pause(pause), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .instruction(instruction), .inst_pc(inst_pc), .count(count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what decode should see and what the memory should be asked.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } ent_t;
    ent_t        mq[$];
    logic [31:0] m_pc, m_addr;
    bit          m_out, m_drop;

    always @(posedge clk) begin : model_upd
        int n;
        bit resp, popped;
        if (reset) begin
            mq.delete();
            m_pc = RESET_PC; m_addr = RESET_PC; m_out = 0; m_drop = 0;
        end else begin
            n      = mq.size();
            resp   = m_out && imem_rvalid;
            popped = (n > 0) && !pause && inst_ready;
            if (redirect) begin
                mq.delete();
                m_pc = {redirect_pc[31:2], 2'b00};
                if (resp) begin m_out = 0; m_drop = 0; end
                else if (m_out) m_drop = 1;
            end else if (resp) begin
                if (popped) void'(mq.pop_front());
                if (!m_drop) begin
                    mq.push_back('{m_pc, imem_rdata});
                    m_pc = m_pc + 32'd4;
                end
                m_out = 0; m_drop = 0;
            end else begin
                if (popped) void'(mq.pop_front());
                if (!m_out && !pause && n < DEPTH) begin
                    m_out = 1; m_addr = m_pc;
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        if (chk_en) begin
            check("count", 32'(count), 32'(mq.size()));
            check("inst_valid", 32'(inst_valid), 32'((mq.size() > 0) && !pause));
            check("imem_req", 32'(imem_req), 32'(m_out));
            if (m_out) check("imem_addr", imem_addr, m_addr);
            if (mq.size() > 0) begin
                check("inst_pc", inst_pc, mq[0].pc);
                check("instruction", instruction, mq[0].word);
            end
        end
    end

    // Memory responder and cycle stepping.
    bit mem_manual = 0;
    bit rnd_mode   = 0;
    int mlat       = 0;
    int mcnt       = 0;
    bit prev_req   = 0;
    bit rose       = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h2008_0005;
        if (a == 32'h4) return 32'h2009_0003;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic mem_respond();
        if (!mem_manual) begin
            if (imem_req) begin
                if (mcnt >= mlat) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = rnd_mode ? $urandom() : mem_word(imem_addr);
                    mcnt = 0;
                    if (rnd_mode) mlat = $urandom_range(0, 3);
                end else begin
                    imem_rvalid = 1'b0;
                    mcnt++;
                end
            end else begin
                imem_rvalid = 1'b0;
                mcnt = 0;
            end
        end
    endtask

    task automatic cyc();
        prev_req = imem_req;
        @(negedge clk);
        #1;
        rose = imem_req && !prev_req;
        mem_respond();
    endtask

    task automatic do_reset();
        reset = 1'b1; pause = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        imem_rvalid = 1'b0; imem_rdata = 32'h0; inst_ready = 1'b0;
        mem_manual = 0; mcnt = 0; mlat = 0;
        cyc();
        chk_en = 1;
        cyc();
        reset = 1'b0;
    endtask

    task automatic wait_rise(input int bound, output bit ok);
        ok = 0;
        for (int i = 0; i < bound; i++) begin
            cyc();
            if (rose) begin ok = 1; break; end
        end
    endtask

    task automatic wait_count(input int n, input int bound, input string name);
        for (int i = 0; i < bound; i++) begin
            if (int'(count) == n) break;
            cyc();
        end
        check(name, 32'(count), 32'(n));
    endtask

    task automatic wait_req(input int bound, input string name);
        for (int i = 0; i < bound; i++) begin
            if (imem_req) break;
            cyc();
        end
        check(name, 32'(imem_req), 32'd1);
    endtask

    initial begin
        logic [31:0] addrs [3];
        logic [31:0] dpc [2];
        logic [31:0] dword [2];
        int na, nd, nv, rises;
        bit ok;

        reset = 1'b1; pause = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        imem_rvalid = 1'b0; imem_rdata = 32'h0; inst_ready = 1'b0;

        // Reset values
        do_reset();
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_imem_addr", imem_addr, RESET_PC);
        check("rst_count", 32'(count), 32'd0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_instruction", instruction, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);

        // 1: sequential fetch, 1-cycle memory, decode always ready
        inst_ready = 1'b1;
        na = 0; nd = 0;
        for (int i = 0; i < 30; i++) begin
            if (inst_valid && nd < 2) begin dpc[nd] = inst_pc; dword[nd] = instruction; nd++; end
            cyc();
            if (rose && na < 3) begin addrs[na] = imem_addr; na++; end
        end
        check("t1_naddr", 32'(na), 32'd3);
        check("t1_addr0", addrs[0], 32'h0);
        check("t1_addr1", addrs[1], 32'h4);
        check("t1_addr2", addrs[2], 32'h8);
        check("t1_pc0", dpc[0], 32'h0);
        check("t1_word0", dword[0], 32'h2008_0005);
        check("t1_pc1", dpc[1], 32'h4);
        check("t1_word1", dword[1], 32'h2009_0003);
        nv = 0;
        for (int i = 0; i < 20; i++) begin
            if (inst_valid) nv++;
            cyc();
        end
        check("t1_rate", 32'(nv), 32'd10);

        // 2: fill until full, single pop, resume at 0x10
        do_reset();
        mlat = 1;
        wait_count(4, 40, "t2_full");
        rises = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (imem_req) rises++;
        end
        check("t2_no_req_full", 32'(rises), 32'd0);
        inst_ready = 1'b1;
        cyc();
        inst_ready = 1'b0;
        check("t2_count3", 32'(count), 32'd3);
        wait_rise(10, ok);
        check("t2_rise", 32'(ok), 32'd1);
        check("t2_addr", imem_addr, 32'h10);

        // 3: redirect while waiting on a slow response
        do_reset();
        wait_count(2, 20, "t3_fill");
        mlat = 4;
        wait_rise(20, ok);
        check("t3_rise0", 32'(ok), 32'd1);
        cyc();
        redirect = 1'b1; redirect_pc = 32'h0000_0043;
        cyc();
        redirect = 1'b0;
        check("t3_count0", 32'(count), 32'd0);
        check("t3_valid0", 32'(inst_valid), 32'd0);
        wait_rise(30, ok);
        check("t3_rise1", 32'(ok), 32'd1);
        check("t3_addr", imem_addr, 32'h40);
        inst_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (inst_valid) break;
            cyc();
        end
        check("t3_first_valid", 32'(inst_valid), 32'd1);
        check("t3_first_pc", inst_pc, 32'h40);

        // 4: redirect coinciding with a response and a pop
        do_reset();
        wait_count(2, 20, "t4_fill");
        mem_manual = 1; imem_rvalid = 1'b0;
        wait_req(10, "t4_req");
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        redirect = 1'b1; redirect_pc = 32'h0000_0100; inst_ready = 1'b1;
        cyc();
        imem_rvalid = 1'b0; redirect = 1'b0; inst_ready = 1'b0;
        check("t4_count0", 32'(count), 32'd0);
        check("t4_req0", 32'(imem_req), 32'd0);
        cyc();
        check("t4_req1", 32'(imem_req), 32'd1);
        check("t4_addr", imem_addr, 32'h100);

        // 5: pause with two entries queued and one request in flight
        do_reset();
        wait_count(2, 20, "t5_fill");
        mem_manual = 1; imem_rvalid = 1'b0;
        wait_req(10, "t5_req");
        rises = 0;
        for (int i = 0; i < 5; i++) begin
            pause = 1'b1; inst_ready = 1'b1;
            imem_rvalid = (i == 1); imem_rdata = 32'hCAFE_0001;
            cyc();
            check("t5_valid_paused", 32'(inst_valid), 32'd0);
            if (rose) rises++;
        end
        imem_rvalid = 1'b0;
        check("t5_count3", 32'(count), 32'd3);
        check("t5_no_rise", 32'(rises), 32'd0);
        check("t5_req_idle", 32'(imem_req), 32'd0);
        pause = 1'b0; inst_ready = 1'b0;
        #1;
        check("t5_valid_after", 32'(inst_valid), 32'd1);
        check("t5_head_pc", inst_pc, 32'h0);
        cyc();

        // 6: reset mid-request, late response ignored; PC wrap
        do_reset();
        mem_manual = 1; imem_rvalid = 1'b0;
        wait_req(10, "t6_req");
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        cyc();
        imem_rvalid = 1'b0;
        check("t6_count0", 32'(count), 32'd0);
        check("t6_req", 32'(imem_req), 32'd1);
        check("t6_addr", imem_addr, RESET_PC);
        mem_manual = 0;
        do_reset();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        cyc();
        redirect = 1'b0;
        wait_rise(10, ok);
        check("t6_wrap_rise0", 32'(ok), 32'd1);
        check("t6_wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        wait_rise(10, ok);
        check("t6_wrap_rise1", 32'(ok), 32'd1);
        check("t6_wrap_addr1", imem_addr, 32'h0000_0000);
        check("t6_wrap_head", inst_pc, 32'hFFFF_FFFC);

        // Randomized traffic against the model
        do_reset();
        rnd_mode = 1;
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(0, 199) == 0);
            pause       = ($urandom_range(0, 9) == 0);
            inst_ready  = ($urandom_range(0, 9) < 6);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = $urandom();
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch stage upstream of the decode/ControlUnit path.
- Owns the fetch PC and issues one-at-a-time requests to a variable-latency instruction memory.
- Buffers returned words with their PCs in a small FIFO and presents them to decode through a valid/ready handshake.
- A redirect from branch/jump resolution flushes the queue and restarts fetch at a new target.

Parameters:
- DEPTH, 4, number of queue entries (power of two, ≥2).
- RESET_PC, 32'h0000_0000, fetch PC after reset.

Ports:
- clk  input  1  system clock, all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- pause  input  1  freeze: blocks new requests and dequeue.
- redirect  input  1  flush the queue and restart fetch at redirect_pc.
- redirect_pc  input  32  new fetch target; bits [1:0] are ignored and treated as 0.
- imem_req  output  1  request valid, registered.
- imem_addr  output  32  request word address, registered, stable while imem_req is high.
- imem_rvalid  input  1  response valid for the outstanding request.
- imem_rdata  input  32  response instruction word.
- inst_valid  output  1  queue head is valid for decode.
- inst_ready  input  1  decode accepts the head this cycle.
- instruction  output  32  instruction word at the queue head.
- inst_pc  output  32  address of instruction at the queue head.
- count  output  ceil(log2(DEPTH+1))  current number of queue entries.

Behaviour:
- Reset values: fetch_pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=RESET_PC, count=0, inst_valid=0. instruction and inst_pc are 0.
- State machine with three states: IDLE, WAIT, DROP.
- IDLE: if !pause and count<DEPTH and !redirect, then imem_req<=1, imem_addr<=fetch_pc, go to WAIT. imem_rvalid is ignored in IDLE.
- WAIT: imem_req stays 1 and imem_addr stays stable until imem_rvalid.
  - On imem_rvalid: push {fetch_pc, imem_rdata}, fetch_pc<=fetch_pc+4 (mod 2^32), imem_req<=0, go to IDLE.
  - Minimum request spacing is 2 cycles.
- DROP: keep imem_req=1 until imem_rvalid. On imem_rvalid, discard the data, imem_req<=0, go to IDLE.
- Only one request is ever outstanding.
- Space check happens at issue. The count cannot rise while a request is in flight, so a push never overflows.
- Handshake: a pop occurs when inst_valid && inst_ready. There is no bypass: a word pushed in cycle k is visible at the head at the earliest in cycle k+1.
- Simultaneous push and pop: count is unchanged, and head and tail both advance.
- Full (count==DEPTH): no issue. Empty: inst_valid=0.
- pause:
  - No new issue.
  - inst_valid is forced to 0, so no pop.
  - A response for an in-flight request is still pushed (or dropped).
  - State and contents are otherwise held.
- redirect has highest priority and is honoured even during pause. In the redirect cycle:
  - The queue is cleared: count<=0, inst_valid=0 next cycle.
  - fetch_pc<=redirect_pc with bits [1:0]=00.
  - A pop in the same cycle still counts as consumed by decode, but has no further effect.
  - If state is WAIT without imem_rvalid: go to DROP.
  - If state is WAIT with imem_rvalid: discard the response and go to IDLE.
  - If state is DROP: stay in DROP, or go to IDLE if imem_rvalid.
  - If state is IDLE: no issue this cycle; the next issue uses the new PC.
- Redirect while already in DROP does not create a second drop; the single outstanding response is discarded once.
- Reset mid-WAIT: returns to IDLE. A late imem_rvalid after reset is ignored, and the first issue uses RESET_PC.
- Pointers wrap modulo DEPTH. count runs 0..DEPTH inclusive.

Test Plan:
1. Reset, memory with 1-cycle latency returning 0x20080005, 0x20090003, …, inst_ready=1 → imem_addr sequence 0x0, 0x4, 0x8. Each inst_valid carries the matching inst_pc and word, one instruction per 2 cycles.
2. inst_ready=0, zero-latency-plus-one memory → count climbs to 4, imem_req stays 0 while full. Raise inst_ready for one cycle → count=3, next issue at address 0x10.
3. Redirect to 0x0000_0043 while in WAIT, response arriving 3 cycles later → count=0 next cycle, that response is discarded, and the next request address is 0x40. The first delivered inst_pc is 0x40.
4. Redirect in the same cycle as imem_rvalid and a pop → response not enqueued, count=0, next imem_addr = redirect target.
5. pause asserted for 5 cycles with 2 entries queued and one request in flight → inst_valid=0 throughout, no new imem_req rising edge, in-flight word pushed (count=3). After pause drops, the head is unchanged.
6. Reset asserted while in WAIT, then imem_rvalid pulses after reset → response ignored, count=0, first post-reset imem_addr=RESET_PC. Also check fetch_pc wrap from 0xFFFF_FFFC to 0x0000_0000.
